crc5_usb_tx: RTL and testbench
==============================

Name: crc5_usb_tx

Overview:
- Serial transmitter for the CRC-5-USB framed link.
- Accepts an 11-bit message over a valid/ready handshake.
- Shifts the message out MSB first, then the 5-bit CRC-5-USB MSB first: a 16-bit frame, one bit per clk.
- Drives the same serial line the receive side samples; it is the transmit end of that link.

Parameters:
- IDLE_BIT, 1'b1, level driven on out when no frame is in progress.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset; sampled only on rising clk.
- valid  input  1  msg is offered for transmission.
- ready  output  1  block can accept msg this cycle.
- msg  input  11  message, msg[10] sent first.
- out  output  1  registered serial bit.
- sof  output  1  high during the cycle out carries msg[10] (first frame bit).
- busy  output  1  high while a frame is on out.
- done  output  1  one-cycle pulse during the cycle out carries the last CRC bit.

Behaviour:
- Reset values: out=IDLE_BIT, ready=1, sof=0, busy=0, done=0, state IDLE, CRC register 5'b11111, counters 0.
- Accept:
  - Transfer occurs on a rising edge where valid && ready.
  - msg is captured into an 11-bit shift register.
  - Frame bit 0 (msg[10]) appears on out in the cycle after the accept edge: latency 1.
- FSM states:
  - IDLE: ready=1, out=IDLE_BIT. On accept -> DATA.
  - DATA: 11 cycles, out = current shift MSB, bit counter 0..10. After count 10 -> CRC.
  - CRC: 5 cycles, out = inverted CRC remainder MSB first, counter 0..4.
  - After the last CRC bit: -> DATA if a back-to-back accept occurred, else -> IDLE.
- CRC-5-USB algorithm:
  - Polynomial x^5+x^2+1 (0x05), init 5'b11111.
  - Per data bit b: fb = crc[4]^b; crc <= {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b0).
  - Transmitted CRC = ~crc after all 11 data bits, crc[4] first.
  - CRC is computed serially alongside the data shift; no extra cycles.
- CRC register: re-initialised to 5'b11111 on every accept.
- ready timing:
  - ready=1 in IDLE and during the last CRC bit cycle.
  - ready=0 for all other busy cycles.
  - valid during busy is ignored and msg is not sampled.
- Back-to-back:
  - An accept during the last CRC bit starts the next frame with no gap.
  - Contiguous 16-bit frames keep the free-running receive counter aligned.
- sof and busy:
  - sof=1 exactly in DATA count 0.
  - busy=1 in DATA and CRC.
- done: 1 exactly in CRC count 4.
- Reset mid-frame: the frame is abandoned. The cycle after the reset edge shows out=IDLE_BIT, ready=1, busy=0, and no done pulse.
- rst and valid asserted together: reset wins, nothing is accepted.
- msg changes after accept: no effect on the frame in flight.

Optional Feature:
- Macro CRC5_USB_TX_ERRINJ_EN.
- Defined:
  - Adds input port err_inj (1 bit), sampled at accept alongside msg.
  - If err_inj=1, the last transmitted CRC bit is inverted, forcing a receiver CRC failure. All timing is unchanged.
- Undefined: no err_inj port; CRC is always correct.

Decomposition:
- Package crc5_usb_pkg holds:
  - CRC5_POLY=5'b00101, CRC5_INIT=5'b11111.
  - MSG_W=11, CRC_W=5, FRAME_W=16.
  - Enum tx_state_t {IDLE, DATA, CRC}.
- Sub-module crc5_usb_serial: a 5-bit serial CRC engine.
  - Ports: clk, rst, init, en, bit_in, crc.
  - Instanced here; reusable by the receive side.

Test Plan:
- Reset then msg=11'h000 with valid=1 one cycle -> out data bits all 0, then CRC bits 0,1,0,0,0. sof on the first bit, done on the 16th bit, then out=1 and ready=1.
- msg=11'h7FF -> eleven 1s on out, then CRC bits 0,0,0,1,0.
- valid held high with msg 11'h000 then 11'h7FF -> 32 contiguous bits with no idle gap. ready high only in bit-16 cycles, second sof in the cycle after the first done.
- Accept, then assert rst at data bit 5 -> the next cycle shows out=1, busy=0, ready=1, and no done. A new accept then produces a correct frame for 11'h000.
- valid toggling while busy with random msg -> frame content unchanged. Only the capture at the ready cycle is transmitted; scoreboard against a 16-bit reference model of the CRC algorithm.
- With CRC5_USB_TX_ERRINJ_EN: msg=11'h000, err_inj=1 -> CRC bits 0,1,0,0,1. With err_inj=0 -> 0,1,0,0,0.

Source files
------------

// File: rtl/crc5_usb_pkg.sv
// Shared constants, state type and serial step function for the CRC-5-USB link.
package crc5_usb_pkg;

  localparam int unsigned MSG_W   = 11;
  localparam int unsigned CRC_W   = 5;
  localparam int unsigned FRAME_W = MSG_W + CRC_W;

  localparam logic [CRC_W-1:0] CRC5_POLY = 5'b00101;
  localparam logic [CRC_W-1:0] CRC5_INIT = 5'b11111;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC
  } tx_state_t;

  function automatic logic [CRC_W-1:0] crc5_step(input logic [CRC_W-1:0] c, input logic b);
    return {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ b) ? CRC5_POLY : '0);
  endfunction

endpackage

// File: rtl/crc5_usb_serial.sv
// Bit-serial CRC-5-USB engine; init may coincide with en to absorb the first bit.
module crc5_usb_serial
  import crc5_usb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= CRC5_INIT;
    end else if (init) begin
      crc <= en ? crc5_step(CRC5_INIT, bit_in) : CRC5_INIT;
    end else if (en) begin
      crc <= crc5_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/crc5_usb_tx.sv
// CRC-5-USB serial frame transmitter: 11 message bits then 5 inverted CRC bits, MSB first.
// Optional CRC error injection enabled by defining CRC5_USB_TX_ERRINJ_EN.
module crc5_usb_tx
  import crc5_usb_pkg::*;
#(
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CRC5_USB_TX_ERRINJ_EN
  input  logic             err_inj,
`endif
  input  logic             valid,
  output logic             ready,
  input  logic [MSG_W-1:0] msg,
  output logic             out,
  output logic             sof,
  output logic             busy,
  output logic             done
);

  tx_state_t        state;
  logic [MSG_W-1:0] shift_q;
  logic [3:0]       cnt;
  logic [CRC_W-1:0] crc;
  logic             accept;
  logic             eng_en;
  logic             eng_bit;
  logic             crc_bit;
  logic             err_q;

  assign accept = valid && ready;

  // The engine runs one bit ahead of out so the full CRC is ready when DATA ends.
  assign eng_en  = accept || (state == DATA && cnt != 4'd10);
  assign eng_bit = accept ? msg[MSG_W-1] : shift_q[MSG_W-2];

  crc5_usb_serial u_crc (
    .clk    (clk),
    .rst    (rst),
    .init   (accept),
    .en     (eng_en),
    .bit_in (eng_bit),
    .crc    (crc)
  );

  always_comb begin
    crc_bit = ~crc[0] ^ err_q;
    case (cnt)
      4'd0:    crc_bit = ~crc[3];
      4'd1:    crc_bit = ~crc[2];
      4'd2:    crc_bit = ~crc[1];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shift_q <= '0;
      out     <= IDLE_BIT;
      ready   <= 1'b1;
      sof     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      sof  <= 1'b0;
      done <= 1'b0;
      if (accept) begin
        state   <= DATA;
        cnt     <= '0;
        shift_q <= msg;
        out     <= msg[MSG_W-1];
        sof     <= 1'b1;
        busy    <= 1'b1;
        ready   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          DATA: begin
            shift_q <= {shift_q[MSG_W-2:0], 1'b0};
            if (cnt == 4'd10) begin
              state <= CRC;
              cnt   <= '0;
              out   <= ~crc[4];
            end else begin
              cnt <= cnt + 4'd1;
              out <= shift_q[MSG_W-2];
            end
          end
          CRC: begin
            if (cnt == 4'd4) begin
              state <= IDLE;
              cnt   <= '0;
              out   <= IDLE_BIT;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 4'd1;
              out <= crc_bit;
              if (cnt == 4'd3) begin
                ready <= 1'b1;
                done  <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CRC5_USB_TX_ERRINJ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= err_inj;
    end
  end
`else
  assign err_q = 1'b0;
`endif

endmodule

// File: tb/tb_crc5_usb_tx.sv
// Self-checking bench for crc5_usb_tx: directed frames plus randomized frames vs a
// polynomial-division reference model. Covers CRC5_USB_TX_ERRINJ_EN when defined.
module tb_crc5_usb_tx;

`ifdef CRC5_USB_TX_ERRINJ_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [10:0] msg;
  logic        out;
  logic        sof;
  logic        busy;
  logic        done;
  logic        err_inj;

  int checks = 0;
  int errors = 0;

  crc5_usb_tx dut (
    .clk     (clk),
    .rst     (rst),
`ifdef CRC5_USB_TX_ERRINJ_EN
    .err_inj (err_inj),
`endif
    .valid   (valid),
    .ready   (ready),
    .msg     (msg),
    .out     (out),
    .sof     (sof),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Reference: remainder of (msg*x^5 + init*x^11) mod (x^5+x^2+1), inverted and appended.
  function automatic logic [15:0] ref_frame(input logic [10:0] m, input logic e);
    logic [15:0] d;
    d = {m, 5'b0} ^ 16'hF800;
    for (int i = 15; i >= 5; i--) begin
      if (d[i]) d = d ^ (16'h0025 << (i - 5));
    end
    return {m, ~d[4:0] ^ {4'b0, e}};
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [10:0] m, input logic e);
    @(negedge clk);
    valid   = 1'b1;
    msg     = m;
    err_inj = e;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic check_frame(input logic [15:0] exp, input bit noise, input bit chain,
                             input logic [10:0] nmsg);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("out[%0d]", i), out, exp[15-i]);
      chk($sformatf("sof[%0d]", i), sof, i == 0);
      chk($sformatf("done[%0d]", i), done, i == 15);
      chk($sformatf("busy[%0d]", i), busy, 1'b1);
      chk($sformatf("ready[%0d]", i), ready, i == 15);
      if (i != 15 && noise) begin
        valid = 1'($urandom);
        msg   = 11'($urandom);
      end else begin
        valid = chain;
        msg   = nmsg;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_out"}, out, 1'b1);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_sof"}, sof, 1'b0);
  endtask

  initial begin
    logic [10:0] m;
    rst     = 1'b1;
    valid   = 1'b0;
    msg     = '0;
    err_inj = 1'b0;
    repeat (2) @(posedge clk);
    check_idle("reset");
    rst = 1'b0;

    // All-zero and all-one messages with known CRC tails.
    start(11'h000, 1'b0);
    check_frame(16'h0008, 1'b0, 1'b0, 11'h000);
    check_idle("after_zero");
    start(11'h7FF, 1'b0);
    check_frame(16'hFFE2, 1'b0, 1'b0, 11'h000);
    check_idle("after_ones");

    // Back-to-back frames with valid held high.
    start(11'h000, 1'b0);
    valid = 1'b1;
    msg   = 11'h7FF;
    check_frame(16'h0008, 1'b0, 1'b1, 11'h7FF);
    check_frame(16'hFFE2, 1'b0, 1'b0, 11'h000);
    check_idle("after_b2b");

    // Reset during data bit 5 abandons the frame.
    start(11'h000, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    check_idle("midreset");
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("ghost_done[%0d]", i), done, 1'b0);
      chk($sformatf("ghost_busy[%0d]", i), busy, 1'b0);
    end

    // rst and valid together: nothing accepted.
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b1;
    msg   = 11'h7FF;
    check_idle("rst_valid");
    rst   = 1'b0;
    valid = 1'b0;
    check_idle("rst_valid_after");
    start(11'h000, 1'b0);
    check_frame(16'h0008, 1'b0, 1'b0, 11'h000);

    // Random messages with valid/msg noise while busy.
    for (int n = 0; n < 10; n++) begin
      m = 11'($urandom);
      start(m, ERR_EN ? 1'($urandom) : 1'b0);
      check_frame(ref_frame(m, err_inj && ERR_EN), 1'b1, 1'b0, 11'h000);
    end
    check_idle("after_random");

`ifdef CRC5_USB_TX_ERRINJ_EN
    start(11'h000, 1'b1);
    check_frame(16'h0009, 1'b0, 1'b0, 11'h000);
    start(11'h000, 1'b0);
    check_frame(16'h0008, 1'b0, 1'b0, 11'h000);
    check_idle("after_errinj");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
